// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage register with load formatting, writeback select and retired-instruction counter.
// Optional same-cycle write-through forwarding to decode is enabled by defining MEM_WB_FWD_EN.
module mem_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_reg_write,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_load_data,
  input  logic            stall,
  input  logic            flush,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_write_data,
  output logic            wb_valid,
  output logic [XLEN-1:0] instret
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_read_data1,
  input  logic [XLEN-1:0] rf_read_data2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2
`endif
);

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] instret_q, instret_d;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_fmt;
  logic [XLEN-1:0] wb_data;

  // Lane select from the low address bits; a[0] is ignored for halfwords.
  always_comb begin
    ld_byte = 8'h00;
    case (in_alu_result[1:0])
      2'd0: ld_byte = in_load_data[7:0];
      2'd1: ld_byte = in_load_data[15:8];
      2'd2: ld_byte = in_load_data[23:16];
      2'd3: ld_byte = in_load_data[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = in_alu_result[1] ? in_load_data[31:16] : in_load_data[15:0];
  end

  always_comb begin
    ld_fmt = in_load_data;
    case (in_funct3)
      3'd0: ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'd1: ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'd4: ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
      3'd5: ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_fmt = in_load_data;
    endcase
  end

  always_comb begin
    wb_data = '0;
    case (in_wb_sel)
      WB_ALU:  wb_data = in_alu_result;
      WB_LOAD: wb_data = ld_fmt;
      WB_PC4:  wb_data = in_pc_plus4;
      default: wb_data = '0;
    endcase
  end

  // Flush only clears valid; payload fields are don't-care and simply hold.
  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    rd_d        = rd_q;
    data_d      = data_q;
    instret_d   = instret_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      reg_write_d = in_reg_write & (in_wb_sel != 2'd3);
      rd_d        = in_rd;
      data_d      = wb_data;
      if (in_valid) instret_d = instret_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      data_q      <= '0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      instret_q   <= instret_d;
    end
  end

  assign rf_we         = valid_q & reg_write_q & (rd_q != 5'd0);
  assign rf_rd         = rd_q;
  assign rf_write_data = data_q;
  assign wb_valid      = valid_q;
  assign instret       = instret_q;

`ifdef MEM_WB_FWD_EN
  // rf_we already excludes x0, so rsK == 0 never forwards.
  assign fwd_data1 = (rf_we && rs1 == rf_rd) ? rf_write_data : rf_read_data1;
  assign fwd_data2 = (rf_we && rs2 == rf_rd) ? rf_write_data : rf_read_data2;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: behavioural model checked after every edge plus literal pins.
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result, in_pc_plus4, in_load_data;
  logic [2:0]  in_funct3;
  logic        stall, flush;
  logic        rf_we, wb_valid;
  logic [4:0]  rf_rd;
  logic [31:0] rf_write_data, instret;
`ifdef MEM_WB_FWD_EN
  logic [4:0]  rs1, rs2;
  logic [31:0] rf_read_data1, rf_read_data2, fwd_data1, fwd_data2;
`endif

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_rd(in_rd),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4),
    .in_funct3(in_funct3), .in_load_data(in_load_data),
    .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .wb_valid(wb_valid), .instret(instret)
`ifdef MEM_WB_FWD_EN
    , .rs1(rs1), .rs2(rs2), .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model of the architecturally visible stage contents.
  logic        m_valid, m_rw;
  logic [4:0]  m_rd;
  logic [31:0] m_data, m_instret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] a,
                                             input logic [2:0] f3);
    logic [31:0] b, h;
    b = (word >> (8 * a)) & 32'hFF;
    h = (word >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
      3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4: return b;
      3'd5: return h;
      default: return word;
    endcase
  endfunction

  task automatic model_edge();
    if (flush) m_valid = 1'b0;
    else if (!stall) begin
      m_valid = in_valid;
      m_rw    = in_reg_write && (in_wb_sel != 2'd3);
      m_rd    = in_rd;
      case (in_wb_sel)
        2'd0: m_data = in_alu_result;
        2'd1: m_data = load_value(in_load_data, in_alu_result[1:0], in_funct3);
        2'd2: m_data = in_pc_plus4;
        default: m_data = 32'd0;
      endcase
      if (in_valid) m_instret = m_instret + 32'd1;
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_rw = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_instret = 32'd0;
  endtask

  task automatic compare();
    chk("wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_valid && m_rw && (m_rd != 5'd0)});
    chk("instret", instret, m_instret);
    if (m_valid) begin
      chk("rf_rd", {27'd0, rf_rd}, {27'd0, m_rd});
      chk("rf_write_data", rf_write_data, m_data);
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #2;
    compare();
  endtask

  task automatic drv(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [2:0] f3, input logic st, input logic fl);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_wb_sel = sel;
    in_alu_result = alu; in_funct3 = f3; stall = st; flush = fl;
  endtask

  logic [31:0] ld_addr [5] = '{32'h103, 32'h101, 32'h102, 32'h100, 32'h100};
  logic [2:0]  ld_f3   [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [31:0] ld_exp  [5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80F1, 32'h00007F22, 32'h80F17F22};
  logic [31:0] held_data, held_cnt;

  initial begin
    rst_n = 1'b0;
    drv(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0, 1'b0, 1'b0);
    in_pc_plus4 = 32'h0000_2004;
    in_load_data = 32'h80F17F22;
`ifdef MEM_WB_FWD_EN
    rs1 = 5'd0; rs2 = 5'd0; rf_read_data1 = 32'd0; rf_read_data2 = 32'd0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    compare();
    chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset_rf_write_data", rf_write_data, 32'd0);
    rst_n = 1'b1;

    // Basic ALU writeback
    drv(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234, 3'd2, 1'b0, 1'b0);
    cyc();
    chk("alu_data_lit", rf_write_data, 32'h1234);
    chk("alu_instret_lit", instret, 32'd1);

    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 1'b1, 5'd6, 2'd1, ld_addr[i], ld_f3[i], 1'b0, 1'b0);
      cyc();
      chk($sformatf("load%0d_lit", i), rf_write_data, ld_exp[i]);
    end

    drv(1'b1, 1'b1, 5'd9, 2'd2, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();
    chk("pc4_lit", rf_write_data, 32'h2004);

    // Write to x0 retires but never writes
    drv(1'b1, 1'b1, 5'd0, 2'd0, 32'hDEAD, 3'd0, 1'b0, 1'b0);
    cyc();
    chk("x0_we_lit", {31'd0, rf_we}, 32'd0);
    chk("x0_valid_lit", {31'd0, wb_valid}, 32'd1);

    drv(1'b1, 1'b1, 5'd9, 2'd3, 32'hBEEF, 3'd0, 1'b0, 1'b0);
    cyc();
    chk("sel3_we_lit", {31'd0, rf_we}, 32'd0);

    drv(1'b0, 1'b1, 5'd4, 2'd0, 32'h77, 3'd0, 1'b0, 1'b0);
    cyc();

    // Stall holds for 3 cycles with only one count
    drv(1'b1, 1'b1, 5'd10, 2'd0, 32'h55, 3'd0, 1'b0, 1'b0);
    cyc();
    held_data = rf_write_data;
    held_cnt  = instret;
    drv(1'b1, 1'b1, 5'd11, 2'd0, 32'h66, 3'd0, 1'b1, 1'b0);
    repeat (3) cyc();
    chk("stall_data_lit", rf_write_data, held_data);
    chk("stall_cnt_lit", instret, held_cnt);
    chk("stall_we_lit", {31'd0, rf_we}, 32'd1);

    // Flush beats stall
    drv(1'b1, 1'b1, 5'd12, 2'd0, 32'h99, 3'd0, 1'b1, 1'b1);
    cyc();
    chk("flush_valid_lit", {31'd0, wb_valid}, 32'd0);
    chk("flush_cnt_lit", instret, held_cnt);

    // Async reset mid-stall with pending write
    drv(1'b1, 1'b1, 5'd13, 2'd0, 32'hABC, 3'd0, 1'b0, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 5'd14, 2'd0, 32'hDEF, 3'd0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("areset_we_lit", {31'd0, rf_we}, 32'd0);
    chk("areset_cnt_lit", instret, 32'd0);
    chk("areset_valid_lit", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(1'b1, 1'b1, 5'd7, 2'd0, 32'hAA, 3'd0, 1'b0, 1'b0);
    cyc();
    chk("post_reset_cnt_lit", instret, 32'd1);

`ifdef MEM_WB_FWD_EN
    rf_read_data1 = 32'h1111; rf_read_data2 = 32'h2222;
    rs1 = 5'd7; rs2 = 5'd8;
    #1;
    chk("fwd1_hit", fwd_data1, 32'hAA);
    chk("fwd2_miss", fwd_data2, 32'h2222);
    rs1 = 5'd0;
    #1;
    chk("fwd1_x0", fwd_data1, 32'h1111);
`endif

    // Counter wrap
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    m_instret = 32'hFFFF_FFFF;
    chk("preset_cnt", instret, 32'hFFFF_FFFF);
    drv(1'b1, 1'b1, 5'd3, 2'd0, 32'h1, 3'd0, 1'b0, 1'b0);
    cyc();
    chk("wrap_lit", instret, 32'd0);
    drv(1'b0, 1'b0, 5'd0, 2'd0, 32'h0, 3'd0, 1'b0, 1'b0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-to-writeback pipeline register and writeback formatter for the RV32I pipeline. It captures the retiring instruction from the memory stage and aligns and sign/zero-extends load data. It selects the writeback source and drives the register file write port (`we`, `rd`, `write_data`) for one instruction per cycle. It also keeps a retired-instruction counter and, optionally, provides same-cycle write-through forwarding for decode-stage register reads.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  memory stage holds a real instruction.
- `in_reg_write`  in  1  instruction writes `rd`.
- `in_rd`  in  5  destination register.
- `in_wb_sel`  in  2  writeback source: 0 = ALU, 1 = load, 2 = PC+4, 3 = none.
- `in_alu_result`  in  32  ALU result; also the load address.
- `in_pc_plus4`  in  32  return address for JAL/JALR.
- `in_funct3`  in  3  load width/sign: 0 = LB, 1 = LH, 2 = LW, 4 = LBU, 5 = LHU.
- `in_load_data`  in  32  raw aligned word from data memory.
- `stall`  in  1  hold stage contents.
- `flush`  in  1  kill the incoming instruction.
- `rf_we`  out  1  register file write enable.
- `rf_rd`  out  5  register file write address.
- `rf_write_data`  out  32  register file write data.
- `wb_valid`  out  1  stage holds a valid instruction.
- `instret`  out  32  count of retired instructions.
- Present only with `MEM_WB_FWD_EN`:
  - `rs1`, `rs2`  in  5 each  decode-stage read addresses.
  - `rf_read_data1`, `rf_read_data2`  in  32 each  raw register file read data.
  - `fwd_data1`, `fwd_data2`  out  32 each  forwarded read data.

## Operation
- Stage register fields: `valid_q`, `reg_write_q`, `rd_q`, `data_q`.
  - `data_q` holds the fully formatted writeback value.
  - Formatting is done before the register, not after it.
- Load formatting uses `a = in_alu_result[1:0]`:
  - LB/LBU: select byte `in_load_data[8a+7:8a]`, then sign- or zero-extend.
  - LH/LHU: select halfword by `a[1]` (`a[0]` ignored; misaligned access is not trapped here), then sign- or zero-extend.
  - LW and undefined funct3 (3, 6, 7): raw word.
- Source select:
  - `in_wb_sel` = 0: `in_alu_result`.
  - `in_wb_sel` = 1: formatted load.
  - `in_wb_sel` = 2: `in_pc_plus4`.
  - `in_wb_sel` = 3: 0, and `reg_write_q` is forced low.
- Update priority at each rising edge:
  1. `flush`: `valid_q` ← 0; other fields don't-care. Flush wins over stall.
  2. Else `stall`: all fields hold.
  3. Else: all fields load from inputs; `valid_q` ← `in_valid`.
- Outputs (combinational from register only):
  - `rf_we = valid_q & reg_write_q & (rd_q != 0)`.
  - `rf_rd = rd_q`, `rf_write_data = data_q`, `wb_valid = valid_q`.
- Writes to x0 never assert `rf_we`.
- During stall `rf_we` stays asserted. The register file rewrites the same value, which is idempotent and intended.
- `instret` increments by 1 on each edge that loads a valid instruction (not flush, not stall, `in_valid`=1). It wraps from 0xFFFFFFFF to 0. Stalled cycles never double-count.

## Timing
- Reset (async, `rst_n`=0): `valid_q`=0, `reg_write_q`=0, `rd_q`=0, `data_q`=0, `instret`=0.
  - Therefore `rf_we`=0, `rf_rd`=0, `rf_write_data`=0, `wb_valid`=0.
  - Deassertion is sampled synchronously by the next edge.
- Latency:
  - Inputs captured at edge N drive `rf_*` during cycle N+1.
  - The register file commits at edge N+1.
  - The value is readable from the register file from cycle N+2.
- Reset asserted mid-stall or mid-flush: reset wins immediately; the in-flight instruction is dropped and not counted.

## Configuration
- `MEM_WB_FWD_EN` defined:
  - `fwd_dataK = (rf_we && rsK == rf_rd) ? rf_write_data : rf_read_dataK`.
  - This is combinational and covers the cycle in which the register file has not yet committed the write.
  - `rsK`=0 never forwards, because `rf_we` already excludes x0.
- Not defined: forwarding ports absent. Decode must stall one extra cycle on a WB-to-ID read-after-write.

## Test plan
- Reset, then `in_valid`=1, `in_reg_write`=1, `in_rd`=5, `in_wb_sel`=0, `in_alu_result`=0x1234 → next cycle `rf_we`=1, `rf_rd`=5, `rf_write_data`=0x1234, `instret`=1.
- Loads with `in_load_data`=0x80F17F22:
  - LB at a=3 → 0xFFFFFF80.
  - LBU at a=1 → 0x0000007F.
  - LH at a=2 → 0xFFFF80F1.
  - LHU at a=0 → 0x00007F22.
  - LW → 0x80F17F22.
- `in_rd`=0 with `in_reg_write`=1 → `rf_we`=0, `wb_valid`=1, `instret` increments. `in_wb_sel`=3 → `rf_we`=0.
- Stall held 3 cycles with a valid instruction → outputs constant, `instret` +1 total. Flush and stall in the same cycle → `wb_valid`=0 next cycle, no count.
- `rst_n` pulsed low mid-stream with a pending write → `rf_we`=0 and `instret`=0 immediately, asynchronously.
- `MEM_WB_FWD_EN`, `rf_rd`=7 with `rf_we`=1 and `rf_write_data`=0xAA:
  - `rs1`=7 → `fwd_data1`=0xAA.
  - `rs2`=8 → `fwd_data2`=`rf_read_data2`.
  - `rs1`=0 → `fwd_data1`=`rf_read_data1`.
- `instret` preset near wrap via 0xFFFFFFFF retirements (or forced) → wraps to 0.
